// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: runs mult/multu/div/divu for a fixed
// number of busy cycles and owns the architectural HI/LO registers.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] counter_reg, counter_next;
   logic [1:0]    op_reg;
   logic [31:0]   a_reg, b_reg;
   logic [31:0]   hi_reg, lo_reg;

   logic idle_start, accept_run, finish;

   assign idle_start = (state_reg == S_IDLE) && start;
   assign accept_run = idle_start && (op == OP_MULT || op == OP_MULTU ||
                                      op == OP_DIV  || op == OP_DIVU);
   assign finish     = (state_reg == S_RUN) && (counter_reg == CW'(1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         counter_reg <= '0;
      end else begin
         state_reg   <= state_next;
         counter_reg <= counter_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next   = state_reg;
      counter_next = counter_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept_run) begin
               state_next   = S_RUN;
               counter_next = (op[1]) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
         end
         S_RUN: begin
            counter_next = counter_reg - CW'(1);
            if (finish) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic: busy decodes straight from the state flop
   always_comb begin
      busy = 1'b0;
      if (state_reg == S_RUN) busy = 1'b1;
   end

   // Arithmetic on the latched operands only
   logic        is_signed, is_div;
   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

   assign is_signed = ~op_reg[0];
   assign is_div    = op_reg[1];

   assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
   assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

   // Magnitude divide then sign-fix; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign a_mag = (is_signed && a_reg[31]) ? (32'd0 - a_reg) : a_reg;
   assign b_mag = (is_signed && b_reg[31]) ? (32'd0 - b_reg) : b_reg;
   assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
   assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
   assign quot  = (is_signed && (a_reg[31] ^ b_reg[31])) ? (32'd0 - q_mag) : q_mag;
   assign rem   = (is_signed && a_reg[31]) ? (32'd0 - r_mag) : r_mag;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_reg <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         hi_reg <= '0;
         lo_reg <= '0;
      end else begin
         if (accept_run) begin
            op_reg <= op[1:0];
            a_reg  <= rs_val;
            b_reg  <= rt_val;
         end
         if (finish) begin
            if (!is_div) begin
               {hi_reg, lo_reg} <= is_signed ? prod_s : prod_u;
            end else if (b_reg != 32'd0) begin
               // Divide by zero leaves HI/LO untouched
               hi_reg <= rem;
               lo_reg <= quot;
            end
         end else if (idle_start && op == OP_MTHI) begin
            hi_reg <= rs_val;
         end else if (idle_start && op == OP_MTLO) begin
            lo_reg <= rs_val;
         end
      end
   end

   assign hi_o = hi_reg;
   assign lo_o = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: busy length, HI/LO results, transfers, reset
// and operand capture against hand-computed expectations.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        busy;
   logic [31:0] hi_o, lo_o;

   int n_checks = 0;
   int n_pass   = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-16s got=%08h", tag, got);
      end else begin
         $display("FAIL %-16s got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; issues the op, scrambles operands during RUN, counts busy
   // cycles and checks HI/LO in the first idle cycle. Returns at that negedge.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit poke_mtlo);
      int cnt;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd7;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
         rs_val = $urandom;
         rt_val = $urandom;
         if (poke_mtlo) begin
            start = 1'b1;
            op    = 3'd5;
         end
      end
      start = 1'b0; op = 3'd7;
      check({tag, "_busy"}, 32'(cnt), 32'(exp_cyc));
      check({tag, "_hi"}, hi_o, exp_hi);
      check({tag, "_lo"}, lo_o, exp_lo);
   endtask

   // Called at a negedge; single-edge transfer or no-op, checked a cycle later.
   task automatic xfer(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      start = 1'b1; op = o; rs_val = a; rt_val = 32'h0;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd7;
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, "_busy2"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, hi_o, exp_hi);
      check({tag, "_lo"}, lo_o, exp_lo);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd7; rs_val = '0; rt_val = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);

      xfer("mthi", 3'd4, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);

      run_op("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      // Issued in the first idle cycle after mult: back-to-back acceptance
      run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0);
      run_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("divu",  3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
      run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);

      xfer("mthi11", 3'd4, 32'h11, 32'h11, 32'h80000000);
      xfer("mtlo22", 3'd5, 32'h22, 32'h11, 32'h22);
      run_op("div0",  3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22, 1'b0);
      run_op("divu0", 3'd3, 32'hFFFFFFFF, 32'd0, 10, 32'h11, 32'h22, 1'b0);

      // mtlo attempts during RUN must be ignored
      run_op("mult_ign", 3'd0, 32'h12345678, 32'h10, 5, 32'h1, 32'h23456780, 1'b1);
      xfer("noop6", 3'd6, 32'hCAFEF00D, 32'h1, 32'h23456780);

      // Reset mid-RUN of a div (100/7 would give LO=14, HI=2)
      start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd7;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_hi", hi_o, 32'd0);
      check("midrst_lo", lo_o, 32'd0);
      repeat (15) @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_hi", hi_o, 32'd0);
      check("post_rst_lo", lo_o, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
